// File: rtl/proj_pkg.sv
// rtl/proj_pkg.sv - shared widths, I/O addresses and target-select enum
// Purpose: one place for default bus/field widths, the memory-mapped I/O
//          register addresses, and the enum naming which target the MAR selects.
// Ports:   none (package).
package proj_pkg;

  localparam int DBITS_DEF        = 32;
  localparam int DMEMADDRBITS_DEF = 16;
  localparam int DMEMWORDBITS_DEF = 2;
  localparam int HEXBITS_DEF      = 24;
  localparam int LEDRBITS_DEF     = 10;
  localparam int KEYBITS_DEF      = 4;
  localparam int SWBITS_DEF       = 10;

  localparam logic [31:0] ADDR_HEX_DEF  = 32'hFFFFF000;
  localparam logic [31:0] ADDR_LEDR_DEF = 32'hFFFFF020;
  localparam logic [31:0] ADDR_KEY_DEF  = 32'hFFFFF080;
  localparam logic [31:0] ADDR_SW_DEF   = 32'hFFFFF090;

  typedef enum logic [2:0] {
    T_MEM,
    T_HEX,
    T_LEDR,
    T_KEY,
    T_SW,
    T_NONE
  } tgt_e;

endpackage

// File: rtl/io_sync.sv
// rtl/io_sync.sv - two-flop synchronizer for raw board inputs
// Purpose: bring asynchronous key/switch levels into the clk domain.
//          Output lags the input by two clk edges.
// Ports:   clk   - clock
//          reset - asynchronous active-high reset, loads RESET_VAL
//          d     - raw asynchronous input, WIDTH bits
//          q     - synchronized output, WIDTH bits
module io_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dmem_io_ctrl.sv
// rtl/dmem_io_ctrl.sv - data memory and memory-mapped board I/O behind a MAR
// Purpose: holds the memory address register, a word-addressed data memory and
//          the HEX/LEDR/KEY/SW registers. Writes commit on clk using the MAR
//          held before the edge; reads are combinational from the current MAR.
// Option:  KEY_EDGE_CAPTURE_EN - adds sticky, write-1-to-clear key press flags
//          in KEY bits [2*KEYBITS-1:KEYBITS]. Undefined: those bits read 0.
// Ports:   clk      - clock
//          reset    - asynchronous active-high reset
//          bus_in   - processor bus (MAR load value / write data)
//          ld_mar   - load MAR from bus_in
//          wr_mem   - write bus_in to the MAR target
//          dr_mem   - drive MAR target on mem_out (high-Z otherwise)
//          mem_out  - read data
//          key_in   - raw active-low keys
//          sw_in    - raw switches
//          hex_out  - HEX register, one nibble per digit
//          ledr_out - LED register
module dmem_io_ctrl
  import proj_pkg::*;
#(
  parameter int               DBITS        = DBITS_DEF,
  parameter int               DMEMADDRBITS = DMEMADDRBITS_DEF,
  parameter int               DMEMWORDBITS = DMEMWORDBITS_DEF,
  parameter int               HEXBITS      = HEXBITS_DEF,
  parameter int               LEDRBITS     = LEDRBITS_DEF,
  parameter int               KEYBITS      = KEYBITS_DEF,
  parameter int               SWBITS       = SWBITS_DEF,
  parameter logic [DBITS-1:0] ADDRHEX      = ADDR_HEX_DEF,
  parameter logic [DBITS-1:0] ADDRLEDR     = ADDR_LEDR_DEF,
  parameter logic [DBITS-1:0] ADDRKEY      = ADDR_KEY_DEF,
  parameter logic [DBITS-1:0] ADDRSW       = ADDR_SW_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DBITS-1:0]    bus_in,
  input  logic                ld_mar,
  input  logic                wr_mem,
  input  logic                dr_mem,
  output logic [DBITS-1:0]    mem_out,
  input  logic [KEYBITS-1:0]  key_in,
  input  logic [SWBITS-1:0]   sw_in,
  output logic [HEXBITS-1:0]  hex_out,
  output logic [LEDRBITS-1:0] ledr_out
);

  localparam int AWORD  = DMEMADDRBITS - DMEMWORDBITS;
  localparam int NWORDS = 1 << AWORD;

  logic [DBITS-1:0]   mar;
  tgt_e               tgt;
  logic [DBITS-1:0]   mem [NWORDS];
  logic [AWORD-1:0]   widx;
  logic [DBITS-1:0]   rdata;
  logic [KEYBITS-1:0] key_sync;
  logic [KEYBITS-1:0] key_lvl;
  logic [KEYBITS-1:0] key_cap_rd;
  logic [SWBITS-1:0]  sw_sync;

  assign widx = mar[DMEMADDRBITS-1:DMEMWORDBITS];

  // Exact I/O matches take priority over the memory window.
  always_comb begin
    tgt = T_NONE;
    if (mar == ADDRHEX)                       tgt = T_HEX;
    else if (mar == ADDRLEDR)                 tgt = T_LEDR;
    else if (mar == ADDRKEY)                  tgt = T_KEY;
    else if (mar == ADDRSW)                   tgt = T_SW;
    else if (mar[DBITS-1:DMEMADDRBITS] == '0) tgt = T_MEM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mar      <= '0;
      hex_out  <= '0;
      ledr_out <= '0;
    end else begin
      if (ld_mar)                  mar      <= bus_in;
      if (wr_mem && tgt == T_HEX)  hex_out  <= bus_in[HEXBITS-1:0];
      if (wr_mem && tgt == T_LEDR) ledr_out <= bus_in[LEDRBITS-1:0];
    end
  end

  // Memory contents survive reset; reset only blocks the write port.
  always_ff @(posedge clk) begin
    if (wr_mem && !reset && tgt == T_MEM) mem[widx] <= bus_in;
  end

  io_sync #(
    .WIDTH     (KEYBITS),
    .RESET_VAL ({KEYBITS{1'b1}})
  ) u_key_sync (
    .clk   (clk),
    .reset (reset),
    .d     (key_in),
    .q     (key_sync)
  );

  io_sync #(
    .WIDTH     (SWBITS),
    .RESET_VAL ('0)
  ) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d     (sw_in),
    .q     (sw_sync)
  );

  // Keys are active-low on the board; software sees pressed = 1.
  assign key_lvl = ~key_sync;

`ifdef KEY_EDGE_CAPTURE_EN
  logic [KEYBITS-1:0] key_prev;
  logic [KEYBITS-1:0] key_cap;
  logic [KEYBITS-1:0] key_rise;
  logic [KEYBITS-1:0] key_clr;

  assign key_rise = key_lvl & ~key_prev;
  assign key_clr  = (wr_mem && tgt == T_KEY) ? bus_in[2*KEYBITS-1:KEYBITS] : '0;

  // Rise is ORed last so a press in the same cycle as a clear keeps the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_prev <= '0;
      key_cap  <= '0;
    end else begin
      key_prev <= key_lvl;
      key_cap  <= (key_cap & ~key_clr) | key_rise;
    end
  end

  // The press shows up in the same cycle as the synchronized level.
  assign key_cap_rd = key_cap | key_rise;
`else
  assign key_cap_rd = '0;
`endif

  always_comb begin
    rdata = '0;
    unique case (tgt)
      T_MEM:   rdata = mem[widx];
      T_HEX:   rdata = DBITS'(hex_out);
      T_LEDR:  rdata = DBITS'(ledr_out);
      T_KEY:   rdata = DBITS'({key_cap_rd, key_lvl});
      T_SW:    rdata = DBITS'(sw_sync);
      default: rdata = '0;
    endcase
  end

  assign mem_out = dr_mem ? rdata : {DBITS{1'bz}};

endmodule
